// File: rtl/rot_host_seq.sv
// rot_host_seq: boot-time bus master for the rot block.
// Configures the rot FSM, waits for it to go idle, requests 128 TRNG bits,
// reads them back and checks the final STATUS word. The SoC sees a
// start/busy/done/err handshake.
// Optional feature: define ROT_SEQ_HEALTH_EN to add a popcount health test
// on the captured random data and the health_ones output.
module rot_host_seq #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] BASE         = 32'h1000_0000,
    parameter logic [WIDTH-1:0] OP_FSM_CODE  = 32'd1,
    parameter logic [WIDTH-1:0] OP_TRNG_CODE = 32'd2,
    parameter int               FSM_TMO      = 40,
    parameter int               TRNG_TMO     = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] fsm_bits,
    input  logic [WIDTH-1:0] bus_rdata,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    output logic [127:0]     trng_out,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_wdata,
    output logic             bus_we,
    output logic             bus_re
`ifdef ROT_SEQ_HEALTH_EN
    ,
    output logic [7:0]       health_ones
`endif
);

    // rot register map
    localparam logic [WIDTH-1:0] ADDR_STATUS   = BASE;
    localparam logic [WIDTH-1:0] ADDR_TRNG     = BASE + WIDTH'(77);
    localparam logic [WIDTH-1:0] ADDR_FSM_BITS = BASE + WIDTH'(81);
    localparam logic [WIDTH-1:0] ADDR_OP       = BASE + WIDTH'(127);

    localparam logic [10:0] FSM_LIMIT  = 11'(FSM_TMO);
    localparam logic [10:0] TRNG_LIMIT = 11'(TRNG_TMO);

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_FSM    = 2'd1;
    localparam logic [1:0] ERR_TRNG   = 2'd2;
    localparam logic [1:0] ERR_STATUS = 2'd3;

    typedef enum logic [3:0] {
        IDLE,
        W_CFG,
        W_OPF,
        P_FSM,
        W_OPT,
        P_TRNG,
        R_TRNG,
        C_STAT,
        FIN
    } state_t;

    state_t     state;
    logic       cap;        // 0: RD cycle of a read, 1: CAP cycle
    logic [1:0] word_idx;   // which TRNG word is being read
    logic [10:0] cnt;       // poll-phase cycle counter

    logic [10:0]      cnt_next;
    logic             fsm_ready;
    logic             trng_ready;
    logic             status_ok;
    logic             final_bad;
    logic [WIDTH-1:0] trng_next_addr;

    // Saturating poll counter increment
    assign cnt_next = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;

    // STATUS decoding for the three checks
    assign fsm_ready  = ~bus_rdata[0] & ~bus_rdata[1];
    assign trng_ready = ~bus_rdata[0] & ~bus_rdata[2];
    assign status_ok  = (bus_rdata[31:26] == 6'b001001) && (bus_rdata[5:0] == 6'd0);

    // Address of the following TRNG word (only used while word_idx < 3)
    assign trng_next_addr = ADDR_TRNG + {{(WIDTH-2){1'b0}}, word_idx + 2'd1};

`ifdef ROT_SEQ_HEALTH_EN
    logic [7:0] ones;

    // Population count of the captured random data
    always_comb begin
        ones = 8'd0;
        for (int i = 0; i < 128; i++) begin
            ones = ones + {7'd0, trng_out[i]};
        end
    end

    assign final_bad = !status_ok || (ones < 8'd32) || (ones > 8'd96);
`else
    assign final_bad = !status_ok;
`endif

    // Sequencer FSM; bus strobes are registered and reflect the current state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cap       <= 1'b0;
            word_idx  <= 2'd0;
            cnt       <= 11'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= ERR_OK;
            trng_out  <= 128'd0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
`ifdef ROT_SEQ_HEALTH_EN
            health_ones <= 8'd0;
`endif
        end else begin
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        err       <= ERR_OK;
                        trng_out  <= 128'd0;
                        bus_we    <= 1'b1;
                        bus_addr  <= ADDR_FSM_BITS;
                        bus_wdata <= fsm_bits;
                        state     <= W_CFG;
                    end
                end

                W_CFG: begin
                    bus_we    <= 1'b1;
                    bus_addr  <= ADDR_OP;
                    bus_wdata <= OP_FSM_CODE;
                    state     <= W_OPF;
                end

                W_OPF: begin
                    cnt      <= 11'd0;
                    cap      <= 1'b0;
                    bus_re   <= 1'b1;
                    bus_addr <= ADDR_STATUS;
                    state    <= P_FSM;
                end

                P_FSM: begin
                    cnt <= cnt_next;
                    if (!cap) begin
                        cap <= 1'b1;
                    end else begin
                        cap <= 1'b0;
                        if (fsm_ready) begin
                            bus_we    <= 1'b1;
                            bus_addr  <= ADDR_OP;
                            bus_wdata <= OP_TRNG_CODE;
                            state     <= W_OPT;
                        end else if (cnt >= FSM_LIMIT) begin
                            err   <= ERR_FSM;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end else begin
                            bus_re   <= 1'b1;
                            bus_addr <= ADDR_STATUS;
                        end
                    end
                end

                W_OPT: begin
                    cnt      <= 11'd0;
                    cap      <= 1'b0;
                    bus_re   <= 1'b1;
                    bus_addr <= ADDR_STATUS;
                    state    <= P_TRNG;
                end

                P_TRNG: begin
                    cnt <= cnt_next;
                    if (!cap) begin
                        cap <= 1'b1;
                    end else begin
                        cap <= 1'b0;
                        if (trng_ready) begin
                            word_idx <= 2'd0;
                            bus_re   <= 1'b1;
                            bus_addr <= ADDR_TRNG;
                            state    <= R_TRNG;
                        end else if (cnt >= TRNG_LIMIT) begin
                            err   <= ERR_TRNG;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end else begin
                            bus_re   <= 1'b1;
                            bus_addr <= ADDR_STATUS;
                        end
                    end
                end

                R_TRNG: begin
                    if (!cap) begin
                        cap <= 1'b1;
                    end else begin
                        cap      <= 1'b0;
                        trng_out <= {trng_out[95:0], bus_rdata};
                        bus_re   <= 1'b1;
                        if (word_idx == 2'd3) begin
                            bus_addr <= ADDR_STATUS;
                            state    <= C_STAT;
                        end else begin
                            word_idx <= word_idx + 2'd1;
                            bus_addr <= trng_next_addr;
                        end
                    end
                end

                C_STAT: begin
                    if (!cap) begin
                        cap <= 1'b1;
                    end else begin
                        cap <= 1'b0;
`ifdef ROT_SEQ_HEALTH_EN
                        health_ones <= ones;
`endif
                        if (final_bad) begin
                            err <= ERR_STATUS;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rot_host_seq.sv
// Testbench for rot_host_seq: a small rot bus model answers reads, a
// negedge monitor compares bus writes and end-of-sequence results against
// expectations queued by the stimulus task.
module tb_rot_host_seq;

    localparam logic [31:0] STATUS_ADDR = 32'h1000_0000;
    localparam logic [31:0] TRNG_ADDR   = 32'h1000_004D;
    localparam logic [31:0] FSMB_ADDR   = 32'h1000_0051;
    localparam logic [31:0] OP_ADDR     = 32'h1000_007F;

    logic         clk;
    logic         rst;
    logic         start;
    logic [31:0]  fsm_bits;
    logic [31:0]  bus_rdata;
    logic         busy;
    logic         done;
    logic [1:0]   err;
    logic [127:0] trng_out;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic         bus_we;
    logic         bus_re;
`ifdef ROT_SEQ_HEALTH_EN
    logic [7:0]   health_ones;
`endif

    rot_host_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fsm_bits  (fsm_bits),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .trng_out  (trng_out),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re)
`ifdef ROT_SEQ_HEALTH_EN
        ,
        .health_ones (health_ones)
`endif
    );

    typedef struct {
        logic [1:0]   err;
        logic [127:0] trng;
        int           reads;
        int           lat;
    } result_t;

    logic [63:0] exp_wr[$];
    result_t     exp_res[$];
    result_t     mon_r;
    logic [63:0] mon_w;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int opf_cyc = 0;
    int done_cyc = 0;
    int done_count = 0;
    int trng_reads = 0;
    int trng_polls = 0;
    logic prev_done = 1'b0;

    // rot model knobs
    int          phase = 0;
    int          fsm_polls = 0;
    int          busy_polls = 0;
    bit          fsm_hang = 0;
    bit          trng_hang = 0;
    logic [31:0] final_status = 32'h2400_0000;
    logic [31:0] words[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // rot bus model: read data appears the cycle after bus_re
    always @(posedge clk) begin
        if (bus_we && bus_addr == OP_ADDR) begin
            if (bus_wdata == 32'd1) begin
                phase     <= 1;
                fsm_polls <= 0;
            end else if (bus_wdata == 32'd2) begin
                phase <= 2;
            end
        end
        if (bus_re) begin
            if (bus_addr == STATUS_ADDR) begin
                if (phase == 1) begin
                    bus_rdata <= (fsm_hang || fsm_polls < busy_polls) ? 32'h0000_0002 : 32'h0;
                    fsm_polls <= fsm_polls + 1;
                end else if (phase == 2) begin
                    bus_rdata <= trng_hang ? 32'h0000_0004 : 32'h0;
                end else begin
                    bus_rdata <= final_status;
                end
            end else if (bus_addr >= TRNG_ADDR && bus_addr <= TRNG_ADDR + 32'd3) begin
                bus_rdata <= words[2'(bus_addr - TRNG_ADDR)];
                if (bus_addr == TRNG_ADDR + 32'd3) phase <= 3;
            end else begin
                bus_rdata <= 32'hDEAD_0BAD;
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_we || bus_re)
                checkOutput("we_re_exclusive", 128'(bus_we & bus_re), 128'd0);
            if (bus_we) begin
                if (exp_wr.size() == 0) begin
                    checkOutput("unexpected_write", {64'd0, bus_addr, bus_wdata}, 128'd0);
                end else begin
                    mon_w = exp_wr.pop_front();
                    checkOutput("bus_write", {64'd0, bus_addr, bus_wdata}, {64'd0, mon_w});
                end
                if (bus_addr == OP_ADDR && bus_wdata == 32'd1) opf_cyc = cyc;
            end
            if (bus_re && bus_addr >= TRNG_ADDR && bus_addr <= TRNG_ADDR + 32'd3)
                trng_reads++;
            if (bus_re && bus_addr == STATUS_ADDR && phase == 2)
                trng_polls++;
            if (done) begin
                done_cyc = cyc;
                checkOutput("done_pulse_width", 128'(prev_done), 128'd0);
                if (exp_res.size() == 0) begin
                    checkOutput("unexpected_done", 128'd1, 128'd0);
                end else begin
                    mon_r = exp_res.pop_front();
                    checkOutput("err", 128'(err), 128'(mon_r.err));
                    checkOutput("trng_out", trng_out, mon_r.trng);
                    checkOutput("busy_at_done", 128'(busy), 128'd0);
                    checkOutput("writes_drained", 128'(exp_wr.size()), 128'd0);
                    checkOutput("trng_reads", 128'(trng_reads), 128'(mon_r.reads));
                    if (mon_r.lat >= 0)
                        checkOutput("latency", 128'(cyc - start_cyc), 128'(mon_r.lat));
`ifdef ROT_SEQ_HEALTH_EN
                    if (mon_r.reads == 4)
                        checkOutput("health_ones", 128'(health_ones), 128'($countones(mon_r.trng)));
`endif
                end
                done_count++;
            end
        end
        prev_done = done;
    end

    task automatic applyStimulus(input logic [31:0] bits, input logic [1:0] e_err,
                                 input logic [127:0] e_trng, input int e_reads, input int e_lat,
                                 input int n_wr, input int busy_poke, input bit fin_poke,
                                 input bit wait_done);
        result_t r;
        int base;
        exp_wr.push_back({FSMB_ADDR, bits});
        if (n_wr >= 2) exp_wr.push_back({OP_ADDR, 32'd1});
        if (n_wr >= 3) exp_wr.push_back({OP_ADDR, 32'd2});
        if (wait_done) begin
            r.err = e_err; r.trng = e_trng; r.reads = e_reads; r.lat = e_lat;
            exp_res.push_back(r);
        end
        @(negedge clk); #1;
        trng_reads = 0;
        trng_polls = 0;
        start_cyc  = cyc;
        base       = done_count;
        fsm_bits   = bits;
        start      = 1'b1;
        @(negedge clk); #1;
        start    = 1'b0;
        fsm_bits = $urandom;
        if (wait_done) begin
            for (int i = 0; i < 2000 && done_count == base; i++) begin
                if (i == busy_poke) begin
                    start    = 1'b1;
                    fsm_bits = 32'h5555_AAAA;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk); #1;
            end
            start = 1'b0;
            if (done_count == base) begin
                checkOutput("done_timeout", 128'd0, 128'd1);
                rst = 1'b1;
                exp_wr.delete();
                exp_res.delete();
                @(negedge clk); #1;
                rst = 1'b0;
            end else if (fin_poke) begin
                start    = 1'b1;
                fsm_bits = 32'h7777_7777;
                @(negedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    localparam logic [127:0] DATA_A = 128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F;
    localparam logic [127:0] DATA_B = 128'h12345678_9ABCDEF0_CAFEBABE_5A5A5A5A;

    task automatic loadWords(input logic [127:0] d);
        words[0] = d[127:96];
        words[1] = d[95:64];
        words[2] = d[63:32];
        words[3] = d[31:0];
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        fsm_bits  = 32'h0;
        bus_rdata = 32'h0;
        loadWords(DATA_A);
        repeat (3) @(negedge clk);
        checkOutput("reset_bus_addr", 128'(bus_addr), 128'd0);
        checkOutput("reset_bus_wdata", 128'(bus_wdata), 128'd0);
        checkOutput("reset_bus_we", 128'(bus_we), 128'd0);
        checkOutput("reset_bus_re", 128'(bus_re), 128'd0);
        checkOutput("reset_busy", 128'(busy), 128'd0);
        checkOutput("reset_done", 128'(done), 128'd0);
        checkOutput("reset_err", 128'(err), 128'd0);
        checkOutput("reset_trng_out", trng_out, 128'd0);
        rst = 1'b0;

        // Happy path, 3 busy FSM polls, start poked while busy
        busy_polls = 3; final_status = 32'h2400_0000;
        applyStimulus(32'hF0F0_AAAA, 2'd0, DATA_A, 4, 24, 3, 5, 0, 1);

        // Zero-wait happy path, start poked during FIN
        busy_polls = 0; loadWords(DATA_B);
        applyStimulus(32'h0000_1234, 2'd0, DATA_B, 4, 18, 3, -1, 1, 1);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("fin_start_ignored_busy", 128'(busy), 128'd0);
        checkOutput("fin_start_no_writes", 128'(exp_wr.size()), 128'd0);
        checkOutput("trng_held", trng_out, DATA_B);

        // Back-to-back: start in the cycle right after FIN
        loadWords(DATA_A);
        applyStimulus(32'hA5A5_0001, 2'd0, DATA_A, 4, 18, 3, -1, 0, 1);
        applyStimulus(32'hA5A5_0002, 2'd0, DATA_A, 4, 18, 3, -1, 0, 1);

        // FSM hang
        fsm_hang = 1;
        applyStimulus(32'h1111_2222, 2'd1, 128'd0, 0, -1, 2, -1, 0, 1);
        checkOutput("fsm_tmo_window", 128'((done_cyc - opf_cyc) >= 40 && (done_cyc - opf_cyc) <= 43), 128'd1);
        fsm_hang = 0;

        // TRNG hang
        trng_hang = 1;
        applyStimulus(32'h3333_4444, 2'd2, 128'd0, 0, -1, 3, -1, 0, 1);
        checkOutput("trng_poll_cycles", 128'(trng_polls * 2 >= 1000), 128'd1);
        trng_hang = 0;

        // Final status mismatch keeps the captured data
        final_status = 32'h2400_0001;
        applyStimulus(32'h5555_6666, 2'd3, DATA_A, 4, 18, 3, -1, 0, 1);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("err_held", 128'(err), 128'd3);
        checkOutput("trng_held_on_err", trng_out, DATA_A);
        final_status = 32'h2400_0000;

        // Reset in the middle of TRNG polling
        trng_hang = 1;
        applyStimulus(32'h7777_8888, 2'd0, 128'd0, 0, -1, 3, -1, 0, 0);
        for (int i = 0; i < 300 && trng_polls < 5; i++) @(negedge clk);
        checkOutput("trng_poll_reached", 128'(trng_polls >= 5), 128'd1);
        checkOutput("busy_before_reset", 128'(busy), 128'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_bus_re", 128'(bus_re), 128'd0);
        checkOutput("abort_bus_we", 128'(bus_we), 128'd0);
        checkOutput("abort_busy", 128'(busy), 128'd0);
        checkOutput("abort_done", 128'(done), 128'd0);
        checkOutput("abort_err", 128'(err), 128'd0);
        checkOutput("abort_writes_drained", 128'(exp_wr.size()), 128'd0);
        trng_hang = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full flow after the abort
        applyStimulus(32'hF0F0_AAAA, 2'd0, DATA_A, 4, 18, 3, -1, 0, 1);

        repeat (3) @(negedge clk);
        checkOutput("results_drained", 128'(exp_res.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
